// File: rtl/gsm_cmd_issuer.sv
// gsm_cmd_issuer: queues gameplay command codes and issues them one at a
// time to the game-state manager over a level-held trig/done handshake.
module gsm_cmd_issuer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 3
) (
  input  logic                          clk_1mhz,
  input  logic                          rst,
  input  logic                          cmd_valid,
  input  logic [3:0]                    cmd_code,
  output logic                          cmd_ready,
  input  logic                          done,
  output logic [3:0]                    flag,
  output logic                          trig,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_timeout,
  input  logic                          err_clr,
  output logic [7:0]                    drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_RELEASE
  } state_t;

  state_t         r_state;
  logic [3:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [LW-1:0]  r_level;
  logic [3:0]     r_flag;
  logic           r_trig;
  logic [TW-1:0]  r_tcnt;
  logic [GW-1:0]  r_gcnt;
  logic           r_err;
  logic [7:0]     r_drop;

  logic w_full;
  logic w_empty;
  logic w_nz;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_tmo;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_nz    = (cmd_code != 4'd0);
  assign w_push  = cmd_valid & ~w_full & w_nz;
  assign w_drop  = cmd_valid & w_full & w_nz;
  // Pop only when idle and the manager has fully released done.
  assign w_pop   = (r_state == S_IDLE) & ~w_empty & ~done;
  assign w_tmo   = (r_state == S_ISSUE) & ~done &
                   (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  assign cmd_ready  = ~w_full;
  assign fifo_level = r_level;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign flag       = r_flag;
  assign trig       = r_trig;
  assign err_timeout = r_err;
  assign drop_cnt   = r_drop;

  // Command storage; contents need no reset since level gates every read.
  always_ff @(posedge clk_1mhz) begin
    if (w_push) r_mem[r_wptr] <= cmd_code;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at 2^AW.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky timeout error (set beats clear) and saturating drop counter.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      r_err  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_tmo)        r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  // Handshake FSM: load flag, raise trig, wait ack/timeout, enforce low gap.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_flag  <= '0;
      r_trig  <= 1'b0;
      r_tcnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_flag  <= r_mem[r_rptr];
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!done) begin
            r_trig  <= 1'b1;
            r_tcnt  <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (done || w_tmo) begin
            r_trig  <= 1'b0;
            r_gcnt  <= '0;
            r_state <= S_RELEASE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (done) begin
            r_gcnt <= '0;
          end else if (r_gcnt == GW'(GAP_CYCLES - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsm_cmd_issuer.sv
// tb_gsm_cmd_issuer: directed vector table plus manager-model sequences
// for gsm_cmd_issuer.
`timescale 1ns/1ps
module tb_gsm_cmd_issuer;

  logic       clk_1mhz = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_code = 4'd0;
  logic       cmd_ready;
  logic       done;
  logic [3:0] flag;
  logic       trig;
  logic       busy;
  logic [2:0] fifo_level;
  logic       err_timeout;
  logic       err_clr = 1'b0;
  logic [7:0] drop_cnt;

  logic use_model = 1'b0;
  logic tb_done = 1'b0;
  logic ack_en = 1'b1;
  logic mon_clr = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #500 clk_1mhz = ~clk_1mhz;

  gsm_cmd_issuer dut (
    .clk_1mhz   (clk_1mhz),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .done       (done),
    .flag       (flag),
    .trig       (trig),
    .busy       (busy),
    .fifo_level (fifo_level),
    .err_timeout(err_timeout),
    .err_clr    (err_clr),
    .drop_cnt   (drop_cnt)
  );

  // Manager model: 2-FF trig sync, ack on synced rise, done held 10 cycles.
  logic m_s1, m_s2, m_s2d, m_done;
  int   m_hold;
  assign done = use_model ? m_done : tb_done;

  always @(posedge clk_1mhz) begin
    if (rst) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_s2d <= 1'b0;
      m_done <= 1'b0; m_hold <= 0;
    end else begin
      m_s1  <= trig;
      m_s2  <= m_s1;
      m_s2d <= m_s2;
      if (m_hold > 0) begin
        m_hold <= m_hold - 1;
        if (m_hold == 1) m_done <= 1'b0;
      end else if (m_s2 && !m_s2d && ack_en) begin
        m_done <= 1'b1;
        m_hold <= 10;
      end
    end
  end

  // Handshake monitor: trig rises, flags, high/low run lengths.
  int         rises, low_run, high_run, last_high, v_overlap, v_gap;
  logic       prev_trig;
  logic [3:0] rise_q [$];

  always @(negedge clk_1mhz) begin
    if (mon_clr) begin
      rises = 0; low_run = 0; high_run = 0; last_high = 0;
      v_overlap = 0; v_gap = 0; prev_trig = 1'b0;
      rise_q.delete();
    end else begin
      if (trig && !prev_trig) begin
        if (done) v_overlap++;
        if (rises > 0 && low_run < 3) v_gap++;
        rises++;
        rise_q.push_back(flag);
        high_run = 0;
      end
      if (!trig && prev_trig) begin
        last_high = high_run;
        low_run = 0;
      end
      if (trig) high_run++;
      else low_run++;
      prev_trig = trig;
    end
  end

  task automatic step();
    @(posedge clk_1mhz);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mon_clr = 1'b1;
    cmd_valid = 1'b0; cmd_code = 4'd0; err_clr = 1'b0; tb_done = 1'b0;
    step(); step();
    rst = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic push(input logic [3:0] c);
    cmd_valid = 1'b1; cmd_code = c;
    step();
    cmd_valid = 1'b0; cmd_code = 4'd0;
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] code;
    logic       dn;
    logic       clr;
    logic       trig;
    logic [3:0] flag;
    int         lvl;
    logic       busy;
    logic       rdy;
    int         drop;
    logic       err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v,
                              input logic [3:0] c, input logic d,
                              input logic cl, input logic t,
                              input logic [3:0] f, input int l,
                              input logic b, input logic rd,
                              input int dr, input logic e);
    vec_t x;
    x.rst = r; x.v = v; x.code = c; x.dn = d; x.clr = cl;
    x.trig = t; x.flag = f; x.lvl = l; x.busy = b; x.rdy = rd;
    x.drop = dr; x.err = e;
    return x;
  endfunction

  localparam int NV = 31;
  vec_t tbl [NV];

  initial begin
    //            rst v code dn clr  trig flag lvl busy rdy drop err
    tbl[0]  = mk(1, 0, 0,  0, 0,   0, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 1, 1,  0, 0,   0, 0, 1, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0,  0, 0,   0, 1, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0,  0, 0,   1, 1, 0, 1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0,  1, 0,   0, 1, 0, 1, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0,  1, 0,   0, 1, 0, 1, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0,  0, 0,   0, 1, 0, 1, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0,  0, 0,   0, 1, 0, 1, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0,  0, 0,   0, 1, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 1, 0,  0, 0,   0, 1, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 1, 2,  1, 0,   0, 1, 1, 1, 1, 0, 0);
    tbl[11] = mk(0, 1, 3,  1, 0,   0, 1, 2, 1, 1, 0, 0);
    tbl[12] = mk(0, 1, 4,  1, 0,   0, 1, 3, 1, 1, 0, 0);
    tbl[13] = mk(0, 1, 5,  1, 0,   0, 1, 4, 1, 0, 0, 0);
    tbl[14] = mk(0, 1, 6,  1, 0,   0, 1, 4, 1, 0, 1, 0);
    tbl[15] = mk(0, 1, 7,  1, 0,   0, 1, 4, 1, 0, 2, 0);
    tbl[16] = mk(0, 1, 0,  1, 0,   0, 1, 4, 1, 0, 2, 0);
    tbl[17] = mk(0, 1, 8,  0, 0,   0, 2, 3, 1, 1, 3, 0);
    tbl[18] = mk(0, 1, 9,  0, 0,   1, 2, 4, 1, 0, 3, 0);
    tbl[19] = mk(0, 0, 0,  1, 0,   0, 2, 4, 1, 0, 3, 0);
    tbl[20] = mk(0, 0, 0,  0, 0,   0, 2, 4, 1, 0, 3, 0);
    tbl[21] = mk(0, 0, 0,  0, 0,   0, 2, 4, 1, 0, 3, 0);
    tbl[22] = mk(0, 0, 0,  0, 0,   0, 2, 4, 1, 0, 3, 0);
    tbl[23] = mk(0, 0, 0,  0, 0,   0, 3, 3, 1, 1, 3, 0);
    tbl[24] = mk(0, 0, 0,  0, 0,   1, 3, 3, 1, 1, 3, 0);
    tbl[25] = mk(0, 0, 0,  1, 0,   0, 3, 3, 1, 1, 3, 0);
    tbl[26] = mk(0, 0, 0,  0, 0,   0, 3, 3, 1, 1, 3, 0);
    tbl[27] = mk(0, 0, 0,  0, 0,   0, 3, 3, 1, 1, 3, 0);
    tbl[28] = mk(0, 0, 0,  0, 0,   0, 3, 3, 1, 1, 3, 0);
    tbl[29] = mk(0, 1, 10, 0, 0,   0, 4, 3, 1, 1, 3, 0);
    tbl[30] = mk(0, 0, 0,  0, 0,   1, 4, 3, 1, 1, 3, 0);

    // Directed vectors with done driven by the bench.
    use_model = 1'b0;
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; cmd_valid = tbl[i].v; cmd_code = tbl[i].code;
      tb_done = tbl[i].dn; err_clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_trig", i), trig, tbl[i].trig);
      chk($sformatf("v%0d_flag", i), flag, tbl[i].flag);
      chk($sformatf("v%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_ready", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("v%0d_drop", i), drop_cnt, tbl[i].drop);
      chk($sformatf("v%0d_err", i), err_timeout, tbl[i].err);
    end

    // Single command against the manager model.
    use_model = 1'b1; ack_en = 1'b1;
    do_reset();
    push(4'd1);
    chk("s1_trig_e0", trig, 0);
    step();
    chk("s1_trig_e1", trig, 0);
    step();
    chk("s1_trig_e2", trig, 1);
    chk("s1_flag", flag, 1);
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    chk("s1_done_seen", done, 1);
    chk("s1_trig_with_done", trig, 1);
    step();
    chk("s1_trig_fall", trig, 0);
    for (int i = 0; i < 20 && done !== 1'b0; i++) step();
    chk("s1_done_low", done, 0);
    step();
    chk("s1_busy_g1", busy, 1);
    step();
    chk("s1_busy_g2", busy, 1);
    step();
    chk("s1_busy_g3", busy, 0);

    // Three back-to-back commands: order, gap, no rise under done.
    do_reset();
    push(4'd1); push(4'd2); push(4'd10);
    for (int i = 0; i < 400 && (busy !== 1'b0 || rises != 3); i++) step();
    step();
    chk("s2_rises", rises, 3);
    chk("s2_flag0", rise_q.size() > 0 ? rise_q[0] : 4'd15, 1);
    chk("s2_flag1", rise_q.size() > 1 ? rise_q[1] : 4'd15, 2);
    chk("s2_flag2", rise_q.size() > 2 ? rise_q[2] : 4'd15, 10);
    chk("s2_overlap", v_overlap, 0);
    chk("s2_gap", v_gap, 0);
    chk("s2_busy", busy, 0);

    // Timeout: manager never acks.
    ack_en = 1'b0;
    do_reset();
    push(4'd5); push(4'd6);
    for (int i = 0; i < 100 && trig !== 1'b1; i++) step();
    chk("s4_rise1", trig, 1);
    for (int i = 0; i < 100 && trig !== 1'b0; i++) step();
    chk("s4_fall1", trig, 0);
    chk("s4_err_set", err_timeout, 1);
    for (int i = 0; i < 20 && trig !== 1'b1; i++) step();
    chk("s4_rise2", trig, 1);
    chk("s4_flag2", flag, 6);
    chk("s4_high_len", last_high, 64);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("s4_err_clr", err_timeout, 0);
    for (int i = 0; i < 62; i++) step();
    chk("s4_trig_hold", trig, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("s4_fall2", trig, 0);
    chk("s4_set_wins", err_timeout, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("s4_err_clr2", err_timeout, 0);

    // Reset mid-handshake with entries queued.
    do_reset();
    push(4'd1); push(4'd2); push(4'd3);
    for (int i = 0; i < 10 && trig !== 1'b1; i++) step();
    chk("s5_trig", trig, 1);
    chk("s5_level", fifo_level, 2);
    rst = 1'b1; mon_clr = 1'b1;
    step();
    chk("s5_rst_trig", trig, 0);
    chk("s5_rst_level", fifo_level, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_flag", flag, 0);
    chk("s5_rst_ready", cmd_ready, 1);
    rst = 1'b0;
    step();
    mon_clr = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("s5_no_trig", rises, 0);

    // Zero code is silently discarded.
    cmd_valid = 1'b1; cmd_code = 4'd0;
    step(); step();
    cmd_valid = 1'b0;
    step(); step();
    chk("s6_level", fifo_level, 0);
    chk("s6_drop", drop_cnt, 0);
    chk("s6_no_trig", rises, 0);
    chk("s6_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
